// File: rtl/flow_extrema_if.sv
// Sample-stream and per-frame result bundle for flow_extrema.
// The master drives samples and receives results; the slave is the extremum finder.
interface flow_extrema_if #(
  parameter int DATAWIDTH = 64,
  parameter int IDXW      = 16
);
  logic [DATAWIDTH-1:0] din;
  logic                 din_tvalid;
  logic                 din_tlast;
  logic                 mode;
  logic [DATAWIDTH-1:0] dout;
  logic [IDXW-1:0]      dout_index;
  logic [IDXW-1:0]      dout_count;
  logic                 dout_ovf;
  logic                 dout_tvalid;

  modport master (
    output din, din_tvalid, din_tlast, mode,
    input  dout, dout_index, dout_count, dout_ovf, dout_tvalid
  );

  modport slave (
    input  din, din_tvalid, din_tlast, mode,
    output dout, dout_index, dout_count, dout_ovf, dout_tvalid
  );
endinterface

// File: rtl/flow_extrema.sv
// Streaming per-frame max/min finder: reports extremum, its position, the beat
// count and a saturation flag one cycle after the last beat of each frame.
module flow_extrema #(
  parameter int DATAWIDTH = 64,
  parameter int IDXW      = 16,
  parameter int SIGNED    = 0
) (
  input  logic           clk,
  input  logic           rst,
  flow_extrema_if.slave  bus
);

  localparam logic [IDXW-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, ACC} state_t;

  state_t               r_state,    w_stateNext;
  logic [DATAWIDTH-1:0] r_acc,      w_accNext;
  logic [IDXW-1:0]      r_accIdx,   w_accIdxNext;
  logic [IDXW-1:0]      r_cnt,      w_cntNext;
  logic                 r_mode,     w_modeNext;
  logic                 r_ovf,      w_ovfNext;
  logic [DATAWIDTH-1:0] r_dout,     w_doutNext;
  logic [IDXW-1:0]      r_doutIdx,  w_doutIdxNext;
  logic [IDXW-1:0]      r_doutCnt,  w_doutCntNext;
  logic                 r_doutOvf,  w_doutOvfNext;
  logic                 r_doutVld,  w_doutVldNext;
  logic                 w_greater,  w_less, w_replace;

  // Strict compare so ties keep the earliest position.
  assign w_greater = (SIGNED != 0) ? ($signed(bus.din) > $signed(r_acc)) : (bus.din > r_acc);
  assign w_less    = (SIGNED != 0) ? ($signed(bus.din) < $signed(r_acc)) : (bus.din < r_acc);
  assign w_replace = r_mode ? w_less : w_greater;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_accIdx  <= '0;
      r_cnt     <= '0;
      r_mode    <= 1'b0;
      r_ovf     <= 1'b0;
      r_dout    <= '0;
      r_doutIdx <= '0;
      r_doutCnt <= '0;
      r_doutOvf <= 1'b0;
      r_doutVld <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_acc     <= w_accNext;
      r_accIdx  <= w_accIdxNext;
      r_cnt     <= w_cntNext;
      r_mode    <= w_modeNext;
      r_ovf     <= w_ovfNext;
      r_dout    <= w_doutNext;
      r_doutIdx <= w_doutIdxNext;
      r_doutCnt <= w_doutCntNext;
      r_doutOvf <= w_doutOvfNext;
      r_doutVld <= w_doutVldNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_accNext     = r_acc;
    w_accIdxNext  = r_accIdx;
    w_cntNext     = r_cnt;
    w_modeNext    = r_mode;
    w_ovfNext     = r_ovf;
    w_doutNext    = r_dout;
    w_doutIdxNext = r_doutIdx;
    w_doutCntNext = r_doutCnt;
    w_doutOvfNext = r_doutOvf;
    w_doutVldNext = 1'b0;

    if (bus.din_tvalid) begin
      if (r_state == IDLE) begin
        w_accNext    = bus.din;
        w_accIdxNext = '0;
        w_cntNext    = IDXW'(1);
        w_modeNext   = bus.mode;
        w_ovfNext    = 1'b0;
      end else begin
        // Once saturated, r_cnt stays at CNT_MAX and doubles as the position.
        if (w_replace) begin
          w_accNext    = bus.din;
          w_accIdxNext = r_cnt;
        end
        if (r_cnt == CNT_MAX) begin
          w_ovfNext = 1'b1;
        end else begin
          w_cntNext = r_cnt + IDXW'(1);
        end
      end

      w_stateNext = bus.din_tlast ? IDLE : ACC;

      if (bus.din_tlast) begin
        w_doutNext    = w_accNext;
        w_doutIdxNext = w_accIdxNext;
        w_doutCntNext = w_cntNext;
        w_doutOvfNext = w_ovfNext;
        w_doutVldNext = 1'b1;
      end
    end
  end

  assign bus.dout        = r_dout;
  assign bus.dout_index  = r_doutIdx;
  assign bus.dout_count  = r_doutCnt;
  assign bus.dout_ovf    = r_doutOvf;
  assign bus.dout_tvalid = r_doutVld;

endmodule
